// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin sharing of one I2C_master command port among
// N_REQ requesters. The winner's command is latched, a single start strobe
// is issued, and the master's completion (read byte, NACK) is handed back
// to the granted requester as a one-cycle done pulse.
// Optional watchdog: define I2C_ARB_TIMEOUT_EN to abort a transaction that
// sees no m_done within TIMEOUT_CYC clocks of waiting.
module i2c_arbiter #(
   parameter int N_REQ       = 4,
   parameter int ADDR_W      = 7,
   parameter int DATA_W      = 8,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*ADDR_W-1:0]  req_addr,
   input  logic [N_REQ-1:0]         req_rw,
   input  logic [N_REQ*DATA_W-1:0]  req_wdata,
   output logic [N_REQ-1:0]         gnt,
   output logic [N_REQ-1:0]         done,
   output logic [DATA_W-1:0]        rdata,
   output logic                     ack_err,
   output logic                     timeout,
   output logic                     m_start,
   output logic [ADDR_W-1:0]        m_addr,
   output logic                     m_rw,
   output logic [DATA_W-1:0]        m_wdata,
   input  logic                     m_busy,
   input  logic                     m_done,
   input  logic [DATA_W-1:0]        m_rdata,
   input  logic                     m_nack
);

   localparam int IDX_W = $clog2(N_REQ);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RELEASE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] gnt_idx;
   logic [IDX_W-1:0] win_idx;
   logic [IDX_W-1:0] cand;
   logic             win_found;
   logic             waiting;
   logic             expire;
   logic             complete;

   assign waiting  = (state == WAIT_BUSY) || (state == WAIT_DONE);
   assign complete = waiting && (m_done || expire);

   // Round-robin search: first set req bit starting at ptr, wrapping mod N_REQ
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = IDX_W'((int'(ptr) + k) % N_REQ);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; a fast master may finish before busy is ever seen
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:      if (win_found) state_nxt = ISSUE;
         ISSUE:     state_nxt = WAIT_BUSY;
         WAIT_BUSY: begin
            if (m_done || expire) state_nxt = RELEASE;
            else if (m_busy)      state_nxt = WAIT_DONE;
         end
         WAIT_DONE: if (m_done || expire) state_nxt = RELEASE;
         RELEASE:   state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // Grant, command latch, completion capture and pointer advance
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gnt     <= '0;
         gnt_idx <= '0;
         ptr     <= '0;
         m_start <= 1'b0;
         m_addr  <= '0;
         m_rw    <= 1'b0;
         m_wdata <= '0;
         done    <= '0;
         rdata   <= '0;
         ack_err <= 1'b0;
      end else begin
         m_start <= 1'b0;
         done    <= '0;
         if (state == IDLE && win_found) begin
            gnt     <= N_REQ'(1) << win_idx;
            gnt_idx <= win_idx;
            m_start <= 1'b1;
            m_addr  <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
            m_rw    <= req_rw[win_idx];
            m_wdata <= req_wdata[int'(win_idx)*DATA_W +: DATA_W];
         end
         if (complete) begin
            done <= gnt;
            if (m_done) begin
               rdata   <= m_rdata;
               ack_err <= m_nack;
            end else begin
               ack_err <= 1'b1;
            end
         end
         if (state == RELEASE) begin
            gnt <= '0;
            ptr <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
         end
      end
   end

`ifdef I2C_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] wd_cnt;

   // Watchdog counts waiting cycles; restarted each time a command issues
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                wd_cnt <= '0;
      else if (state == ISSUE)  wd_cnt <= '0;
      else if (waiting)         wd_cnt <= wd_cnt + 1'b1;
   end

   // A same-edge m_done beats expiry, so expiry requires m_done low
   assign expire = waiting && !m_done && (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));

   // Timeout pulse lands in the same cycle as the done pulse it forces
   always_ff @(posedge clk or posedge reset) begin
      if (reset) timeout <= 1'b0;
      else       timeout <= expire;
   end
`else
   logic unused_timeout_cfg;

   assign expire             = 1'b0;
   assign timeout            = 1'b0;
   assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

endmodule

// File: tb/tb_i2c_arbiter.sv
// Testbench for i2c_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_i2c_arbiter;

   localparam int N  = 4;
   localparam int AW = 7;
   localparam int DW = 8;
   localparam int TO = 16;
`ifdef I2C_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req;
   logic [N*AW-1:0] req_addr;
   logic [N-1:0]    req_rw;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]    gnt;
   logic [N-1:0]    done;
   logic [DW-1:0]   rdata;
   logic            ack_err;
   logic            timeout;
   logic            m_start;
   logic [AW-1:0]   m_addr;
   logic            m_rw;
   logic [DW-1:0]   m_wdata;
   logic            m_busy;
   logic            m_done;
   logic [DW-1:0]   m_rdata;
   logic            m_nack;

   int n_chk  = 0;
   int n_fail = 0;

   i2c_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_rw(req_rw),
      .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .ack_err(ack_err),
      .timeout(timeout), .m_start(m_start), .m_addr(m_addr), .m_rw(m_rw),
      .m_wdata(m_wdata), .m_busy(m_busy), .m_done(m_done), .m_rdata(m_rdata),
      .m_nack(m_nack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   int            mo_owner = -1;   // requester being served, -1 when none
   int            mo_age   = 0;    // clock edges since the grant edge
   int            mo_ptr   = 0;
   bit            mo_closing = 1'b0;
   logic [N-1:0]  e_gnt = '0, e_done = '0;
   logic          e_start = 1'b0, e_to = 1'b0, e_ack = 1'b0, e_rw = 1'b0;
   logic [AW-1:0] e_addr = '0;
   logic [DW-1:0] e_wdata = '0, e_rdata = '0;

   initial forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
         mo_owner = -1; mo_age = 0; mo_ptr = 0; mo_closing = 1'b0;
         e_gnt = '0; e_done = '0; e_start = 1'b0; e_to = 1'b0; e_ack = 1'b0;
         e_rw = 1'b0; e_addr = '0; e_wdata = '0; e_rdata = '0;
      end else begin
         e_start = 1'b0; e_done = '0; e_to = 1'b0;
         if (mo_closing) begin
            mo_closing = 1'b0;
            e_gnt      = '0;
            mo_ptr     = (mo_owner + 1) % N;
            mo_owner   = -1;
         end else if (mo_owner < 0) begin
            if (req != '0) begin
               for (int k = 0; k < N; k++)
                  if (mo_owner < 0 && req[(mo_ptr + k) % N]) mo_owner = (mo_ptr + k) % N;
               e_gnt   = N'(1) << mo_owner;
               e_start = 1'b1;
               e_addr  = req_addr[mo_owner*AW +: AW];
               e_rw    = req_rw[mo_owner];
               e_wdata = req_wdata[mo_owner*DW +: DW];
               mo_age  = 0;
            end
         end else begin
            mo_age++;
            // age 1 is the issue edge: master handshake is not looked at yet
            if (mo_age >= 2) begin
               if (m_done) begin
                  e_done = e_gnt; e_rdata = m_rdata; e_ack = m_nack; mo_closing = 1'b1;
               end else if (TO_EN && mo_age == TO + 1) begin
                  e_done = e_gnt; e_ack = 1'b1; e_to = 1'b1; mo_closing = 1'b1;
               end
            end
         end
      end
   end

   // Per-cycle comparison against the model
   initial forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
         chk("gnt", gnt, e_gnt);
         chk("done", done, e_done);
         chk("m_start", m_start, e_start);
         chk("m_addr", m_addr, e_addr);
         chk("m_rw", m_rw, e_rw);
         chk("m_wdata", m_wdata, e_wdata);
         chk("rdata", rdata, e_rdata);
         chk("timeout", timeout, e_to);
         if (e_done != '0) chk("ack_err", ack_err, e_ack);
      end
   end

   // ---------------- model I2C master ----------------
   int            lat_cfg = 5;     // -2 random, -1 never respond, else fixed
   bit            noise = 1'b0;
   bit            fix_data = 1'b0;
   logic [DW-1:0] fix_rdata = '0;
   logic          fix_nack = 1'b0;
   bit            mact = 1'b0;
   int            mlat = 0;

   function automatic int pick_lat();
      int r;
      if (lat_cfg != -2) return lat_cfg;
      r = $urandom_range(0, 9);
      if (r <= 1) return 0;
      if (r == 2) return TO_EN ? -1 : 30;
      if (r == 3) return TO - 2 + $urandom_range(0, 2);
      return $urandom_range(1, 25);
   endfunction

   initial begin
      m_busy = 1'b0; m_done = 1'b0; m_rdata = '0; m_nack = 1'b0;
      forever begin
         @(negedge clk);
         m_done  = 1'b0;
         m_busy  = 1'b0;
         m_rdata = DW'($urandom);
         m_nack  = 1'($urandom_range(0, 1));
         if (m_start) begin
            mact = 1'b1;
            mlat = pick_lat();
         end else if (mact) begin
            if (mlat == 0) begin
               m_done = 1'b1;
               if (fix_data) begin
                  m_rdata = fix_rdata;
                  m_nack  = fix_nack;
               end
               mact = 1'b0;
            end else begin
               m_busy = 1'b1;
               if (mlat > 0) mlat--;
            end
         end else if (noise && mo_owner < 0 && !mo_closing) begin
            m_done = 1'($urandom_range(0, 1));
            m_busy = 1'($urandom_range(0, 1));
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic wait_start(input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget && !ok; c++) begin
         @(negedge clk);
         if (m_start) ok = 1'b1;
      end
   endtask

   task automatic wait_done(input int budget, output bit ok, output int cyc);
      ok = 1'b0; cyc = 0;
      for (int c = 0; c < budget && !ok; c++) begin
         @(negedge clk);
         cyc++;
         if (done != '0) ok = 1'b1;
      end
   endtask

   task automatic serve(input string nm, input logic [N-1:0] exp_gnt, input int budget);
      bit ok;
      int cyc;
      wait_start(12, ok);
      chk({nm, "_start_seen"}, ok, 1);
      if (ok) chk({nm, "_gnt"}, gnt, exp_gnt);
      wait_done(budget, ok, cyc);
      chk({nm, "_done_seen"}, ok, 1);
      if (ok) chk({nm, "_done"}, done, exp_gnt);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   int rr_exp[5] = '{0, 1, 2, 3, 0};

   initial begin
      bit ok;
      int cyc;
      reset = 1'b1; req = '0; req_rw = '0;
      req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_gnt", gnt, 0);       chk("rst_done", done, 0);
      chk("rst_m_start", m_start, 0); chk("rst_m_addr", m_addr, 0);
      chk("rst_m_wdata", m_wdata, 0); chk("rst_rdata", rdata, 0);
      chk("rst_ack_err", ack_err, 0); chk("rst_timeout", timeout, 0);

      // Single write from requester 1
      lat_cfg = 19;
      req_addr[1*AW +: AW] = 7'h50; req_wdata[1*DW +: DW] = 8'hA5; req_rw[1] = 1'b0;
      req = 4'b0010;
      wait_start(12, ok);
      chk("wr_start_seen", ok, 1);
      chk("wr_gnt", gnt, 4'b0010); chk("wr_m_addr", m_addr, 7'h50);
      chk("wr_m_wdata", m_wdata, 8'hA5); chk("wr_m_rw", m_rw, 0);
      @(negedge clk);
      chk("wr_m_start_drop", m_start, 0);
      wait_done(60, ok, cyc);
      chk("wr_done_seen", ok, 1);
      chk("wr_done", done, 4'b0010); chk("wr_ack_err", ack_err, 0);
      req = '0;

      // Read with NACK from requester 0
      lat_cfg = 5; fix_data = 1'b1; fix_rdata = 8'h7E; fix_nack = 1'b1;
      req_addr[0 +: AW] = 7'h3C; req_rw[0] = 1'b1;
      req = 4'b0001;
      wait_start(12, ok);
      chk("rd_start_seen", ok, 1);
      chk("rd_gnt", gnt, 4'b0001); chk("rd_m_addr", m_addr, 7'h3C); chk("rd_m_rw", m_rw, 1);
      wait_done(30, ok, cyc);
      chk("rd_done_seen", ok, 1);
      chk("rd_done", done, 4'b0001); chk("rd_rdata", rdata, 8'h7E); chk("rd_ack_err", ack_err, 1);
      req = '0; fix_data = 1'b0;

      // Round-robin with all requesters asserted, starting from ptr = 0
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      lat_cfg = 3;
      req = 4'b1111;
      for (int i = 0; i < 5; i++) serve("rr", N'(1) << rr_exp[i], 20);
      req = 4'b0101;
      serve("rr_ptr1", 4'b0100, 20);
      req = '0;

      // Fast master: m_done one clock after m_start, busy never raised
      lat_cfg = 0;
      req = 4'b0001;
      wait_start(12, ok);
      chk("fast_start_seen", ok, 1);
      wait_done(10, ok, cyc);
      chk("fast_done_seen", ok, 1);
      chk("fast_latency", cyc, 2);
      chk("fast_done", done, 4'b0001);
      req = '0;

      // Silent master: watchdog fires, or the grant is held indefinitely
      lat_cfg = TO_EN ? -1 : 60;
      req = 4'b1000;
      wait_start(12, ok);
      chk("hang_start_seen", ok, 1);
      if (TO_EN) begin
         wait_done(40, ok, cyc);
         chk("to_done_seen", ok, 1);
         chk("to_latency", cyc, TO + 1);
         chk("to_pulse", timeout, 1); chk("to_ack_err", ack_err, 1);
         chk("to_done", done, 4'b1000);
         @(negedge clk);
         chk("to_pulse_drop", timeout, 0);
      end else begin
         repeat (50) @(negedge clk);
         chk("hold_gnt", gnt, 4'b1000); chk("hold_done", done, 0); chk("hold_timeout", timeout, 0);
         wait_done(40, ok, cyc);
         chk("hold_done_seen", ok, 1);
      end
      req = '0;
      repeat (3) @(negedge clk);

      // Asynchronous reset in the middle of a busy transaction
      lat_cfg = 30;
      req = 4'b0100;
      wait_start(12, ok);
      chk("mid_start_seen", ok, 1);
      repeat (5) @(negedge clk);
      chk("mid_gnt_held", gnt, 4'b0100);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("mid_rst_gnt", gnt, 0); chk("mid_rst_m_start", m_start, 0); chk("mid_rst_done", done, 0);
      @(negedge clk);
      reset = 1'b0; req = '0;

      // Randomized traffic
      lat_cfg = -2; noise = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         req       = N'($urandom) & N'($urandom);
         req_rw    = N'($urandom);
         req_addr  = (N*AW)'({$urandom, $urandom});
         req_wdata = (N*DW)'({$urandom, $urandom});
      end
      req = '0;
      repeat (60) @(negedge clk);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
